// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter and its benches.
//   REQ_A / REQ_B    : requester indices, also the encoding of the last-grant register
//   MAX_LOCK_DEFAULT : default cap on consecutive locked transfers by one requester
//   lock_owner_e     : which requester (if any) currently holds the lock
package mem_arbiter_pkg;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int unsigned MAX_LOCK_DEFAULT = 16;

  typedef enum logic [1:0] {
    LockNone,
    LockA,
    LockB
  } lock_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory with 1-cycle read latency.
// Round-robin between requesters a and b, with an optional lock that lets one requester
// keep the memory for up to MAX_LOCK consecutive transfers.
//
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   x_valid/lock/write/wmask/
//   x_wdata/x_addr (x = a, b)     request from requester x
//   x_ready                       x is granted this cycle (transfer = x_valid & x_ready)
//   x_rvalid, x_rdata             read response, one cycle after a read transfer of x
//   mem_valid/write/wmask/
//   mem_wdata/mem_addr            request to the memory, muxed from the granted requester
//   mem_rdata                     read data from the memory, valid one cycle after the read
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_LOCK   = MAX_LOCK_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  a_valid,
  input  logic                  a_lock,
  input  logic                  a_write,
  input  logic [3:0]            a_wmask,
  input  logic [31:0]           a_wdata,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_ready,
  output logic                  a_rvalid,
  output logic [31:0]           a_rdata,

  input  logic                  b_valid,
  input  logic                  b_lock,
  input  logic                  b_write,
  input  logic [3:0]            b_wmask,
  input  logic [31:0]           b_wdata,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_ready,
  output logic                  b_rvalid,
  output logic [31:0]           b_rdata,

  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata
);

  // Counter holds 0..MAX_LOCK-1 in practice; sized to represent MAX_LOCK itself for the compare.
  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);

  lock_owner_e     owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            last_q, last_d;
  logic            rd_pend_a_q, rd_pend_a_d;
  logic            rd_pend_b_q, rd_pend_b_d;

  logic            locked_a, locked_b;
  logic            gnt_a, gnt_b;

  // Grant decision. A lock only counts while its holder keeps valid & lock high; otherwise
  // it is treated as already released and plain round-robin applies.
  always_comb begin
    locked_a = (owner_q == LockA) && a_valid && a_lock;
    locked_b = (owner_q == LockB) && b_valid && b_lock;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    if (!rst) begin
      if (locked_a) begin
        gnt_a = 1'b1;
      end else if (locked_b) begin
        gnt_b = 1'b1;
      end else if (a_valid && b_valid) begin
        if (last_q == REQ_B) begin
          gnt_a = 1'b1;
        end else begin
          gnt_b = 1'b1;
        end
      end else begin
        gnt_a = a_valid;
        gnt_b = b_valid;
      end
    end
  end

  // Next state. A grant always implies a transfer since only valid requesters are granted.
  always_comb begin
    owner_d     = LockNone;
    cnt_d       = '0;
    cnt_inc     = '0;
    last_d      = last_q;
    rd_pend_a_d = gnt_a && !a_write;
    rd_pend_b_d = gnt_b && !b_write;

    if (gnt_a) begin
      last_d = REQ_A;
    end else if (gnt_b) begin
      last_d = REQ_B;
    end

    // Any transfer without lock (or no transfer at all) ends the locked streak.
    if ((gnt_a && a_lock) || (gnt_b && b_lock)) begin
      if ((gnt_a && owner_q == LockA) || (gnt_b && owner_q == LockB)) begin
        cnt_inc = cnt_q + CntW'(1);
      end else begin
        cnt_inc = CntW'(1);
      end
      // Forced release: last_d points at the holder, so the other side wins a contest next.
      if (cnt_inc == CntW'(MAX_LOCK)) begin
        owner_d = LockNone;
        cnt_d   = '0;
      end else begin
        owner_d = gnt_a ? LockA : LockB;
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= LockNone;
      cnt_q       <= '0;
      last_q      <= REQ_B;
      rd_pend_a_q <= 1'b0;
      rd_pend_b_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      rd_pend_a_q <= rd_pend_a_d;
      rd_pend_b_q <= rd_pend_b_d;
    end
  end

  // Outputs. Pending flags are cleared asynchronously by rst, so responses are silent in reset.
  always_comb begin
    a_ready   = gnt_a;
    b_ready   = gnt_b;
    mem_valid = gnt_a || gnt_b;
    mem_write = 1'b0;
    mem_wmask = '0;
    mem_wdata = '0;
    mem_addr  = '0;
    if (gnt_a) begin
      mem_write = a_write;
      mem_wmask = a_wmask;
      mem_wdata = a_wdata;
      mem_addr  = a_addr;
    end else if (gnt_b) begin
      mem_write = b_write;
      mem_wmask = b_wmask;
      mem_wdata = b_wdata;
      mem_addr  = b_addr;
    end
    a_rvalid = rd_pend_a_q;
    b_rvalid = rd_pend_b_q;
    a_rdata  = rd_pend_a_q ? mem_rdata : '0;
    b_rdata  = rd_pend_b_q ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a cycle-level
// behavioural model of arbitration, locking and read responses checked on every negedge.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned AW      = 32;
  localparam int          MaxLock = int'(MAX_LOCK_DEFAULT);

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_lock, a_write, a_ready, a_rvalid;
  logic [3:0]  a_wmask;
  logic [31:0] a_wdata, a_rdata;
  logic [AW-1:0] a_addr;
  logic        b_valid, b_lock, b_write, b_ready, b_rvalid;
  logic [3:0]  b_wmask;
  logic [31:0] b_wdata, b_rdata;
  logic [AW-1:0] b_addr;
  logic        mem_valid, mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .MAX_LOCK  (MAX_LOCK_DEFAULT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_lock   (a_lock),
    .a_write  (a_write),
    .a_wmask  (a_wmask),
    .a_wdata  (a_wdata),
    .a_addr   (a_addr),
    .a_ready  (a_ready),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_valid  (b_valid),
    .b_lock   (b_lock),
    .b_write  (b_write),
    .b_wmask  (b_wmask),
    .b_wdata  (b_wdata),
    .b_addr   (b_addr),
    .b_ready  (b_ready),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .mem_valid(mem_valid),
    .mem_write(mem_write),
    .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] addr);
    return int'(addr[11:2]);
  endfunction

  // Memory: word i starts as 0xDEAD0000 | i. Request captured on negedge, applied on posedge.
  logic [31:0] mem [1024];
  initial begin
    logic        c_valid, c_write;
    logic [3:0]  c_mask;
    logic [31:0] c_wdata, c_addr;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD0000 | 32'(i);
    mem_rdata = 32'hBAD0BAD0;
    forever begin
      @(negedge clk);
      c_valid = mem_valid;
      c_write = mem_write;
      c_mask  = mem_wmask;
      c_wdata = mem_wdata;
      c_addr  = mem_addr;
      @(posedge clk);
      if (c_valid && c_write) begin
        for (int j = 0; j < 4; j++) begin
          if (c_mask[j]) mem[idx(c_addr)][8*j +: 8] = c_wdata[8*j +: 8];
        end
        mem_rdata <= 32'hBAD0BAD0;
      end else if (c_valid) begin
        mem_rdata <= mem[idx(c_addr)];
      end else begin
        mem_rdata <= 32'hBAD0BAD0;
      end
    end
  end

  // Behavioural model: winner, lock streak and the read response owed to a requester.
  initial begin
    int          m_last, m_holder, m_streak, m_pend, win, pend_now;
    logic [31:0] m_pend_word;
    logic        v [2];
    logic        lk [2];
    logic        w_write;
    logic [3:0]  w_mask;
    logic [31:0] w_data, w_addr;
    m_last   = int'(REQ_B);
    m_holder = -1;
    m_streak = 0;
    m_pend   = -1;
    m_pend_word = '0;
    forever begin
      @(negedge clk);
      v[0] = a_valid; v[1] = b_valid;
      lk[0] = a_lock; lk[1] = b_lock;
      win = -1;
      if (!rst) begin
        if (m_holder >= 0 && v[m_holder] && lk[m_holder]) win = m_holder;
        else if (v[0] && v[1]) win = 1 - m_last;
        else if (v[0]) win = 0;
        else if (v[1]) win = 1;
      end
      pend_now = rst ? -1 : m_pend;
      w_write = 1'b0; w_mask = '0; w_data = '0; w_addr = '0;
      if (win == 0) begin
        w_write = a_write; w_mask = a_wmask; w_data = a_wdata; w_addr = a_addr;
      end else if (win == 1) begin
        w_write = b_write; w_mask = b_wmask; w_data = b_wdata; w_addr = b_addr;
      end
      chk("m_a_ready",   64'(a_ready),   64'(win == 0));
      chk("m_b_ready",   64'(b_ready),   64'(win == 1));
      chk("m_mem_valid", 64'(mem_valid), 64'(win >= 0));
      chk("m_mem_write", 64'(mem_write), 64'(w_write));
      chk("m_mem_wmask", 64'(mem_wmask), 64'(w_mask));
      chk("m_mem_wdata", 64'(mem_wdata), 64'(w_data));
      chk("m_mem_addr",  64'(mem_addr),  64'(w_addr));
      chk("m_a_rvalid",  64'(a_rvalid),  64'(pend_now == 0));
      chk("m_b_rvalid",  64'(b_rvalid),  64'(pend_now == 1));
      chk("m_a_rdata",   64'(a_rdata),   64'((pend_now == 0) ? m_pend_word : 32'h0));
      chk("m_b_rdata",   64'(b_rdata),   64'((pend_now == 1) ? m_pend_word : 32'h0));
      if (rst) begin
        m_last = int'(REQ_B); m_holder = -1; m_streak = 0; m_pend = -1;
      end else if (win < 0) begin
        m_holder = -1; m_streak = 0; m_pend = -1;
      end else begin
        m_last = win;
        if (lk[win]) begin
          if (m_holder == win) m_streak = m_streak + 1;
          else begin
            m_holder = win;
            m_streak = 1;
          end
          if (m_streak == MaxLock) begin
            m_holder = -1;
            m_streak = 0;
          end
        end else begin
          m_holder = -1;
          m_streak = 0;
        end
        m_pend = w_write ? -1 : win;
        m_pend_word = mem[idx(w_addr)];
      end
    end
  end

  task automatic idle_inputs();
    a_valid = 0; a_lock = 0; a_write = 0; a_wmask = '0; a_wdata = '0; a_addr = '0;
    b_valid = 0; b_lock = 0; b_write = 0; b_wmask = '0; b_wdata = '0; b_addr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One reset cycle with both requesters pushing; everything must stay quiet.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    a_valid = 1; b_valid = 1; a_addr = 32'h100; b_addr = 32'h80;
    sample();
    chk("rst_a_ready",   64'(a_ready),   64'(0));
    chk("rst_b_ready",   64'(b_ready),   64'(0));
    chk("rst_mem_valid", 64'(mem_valid), 64'(0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(0));
    next_cycle();
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    do_reset();

    // Single read by a; response next cycle.
    a_valid = 1; a_addr = 32'h100;
    sample();
    chk("t1_a_ready",  64'(a_ready),  64'(1));
    chk("t1_b_ready",  64'(b_ready),  64'(0));
    chk("t1_mem_addr", 64'(mem_addr), 64'(32'h100));
    next_cycle();
    idle_inputs();
    sample();
    chk("t1_a_rvalid", 64'(a_rvalid), 64'(1));
    chk("t1_a_rdata",  64'(a_rdata),  64'(32'hDEAD0040));
    chk("t1_b_rvalid", 64'(b_rvalid), 64'(0));
    next_cycle();

    // Contested reads after reset alternate a, b, a, b.
    do_reset();
    a_valid = 1; a_addr = 32'h40; b_valid = 1; b_addr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("t2_a_ready", 64'(a_ready), 64'(k % 2 == 0));
      chk("t2_b_ready", 64'(b_ready), 64'(k % 2 == 1));
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Back-to-back reads from different owners.
    a_valid = 1; a_addr = 32'h40;
    sample();
    chk("t3_a_ready", 64'(a_ready), 64'(1));
    next_cycle();
    idle_inputs();
    b_valid = 1; b_addr = 32'h80;
    sample();
    chk("t3_b_ready",  64'(b_ready),  64'(1));
    chk("t3_a_rvalid", 64'(a_rvalid), 64'(1));
    chk("t3_a_rdata",  64'(a_rdata),  64'(32'hDEAD0010));
    next_cycle();
    idle_inputs();
    sample();
    chk("t3_b_rvalid", 64'(b_rvalid), 64'(1));
    chk("t3_b_rdata",  64'(b_rdata),  64'(32'hDEAD0020));
    chk("t3_a_rvalid2", 64'(a_rvalid), 64'(0));
    next_cycle();

    // Masked write via b, then read back.
    b_valid = 1; b_write = 1; b_wmask = 4'b0010; b_wdata = 32'h11223344; b_addr = 32'h200;
    sample();
    chk("t4_b_ready",   64'(b_ready),   64'(1));
    chk("t4_mem_write", 64'(mem_write), 64'(1));
    chk("t4_mem_wmask", 64'(mem_wmask), 64'(4'b0010));
    chk("t4_mem_wdata", 64'(mem_wdata), 64'(32'h11223344));
    next_cycle();
    idle_inputs();
    b_valid = 1; b_addr = 32'h200;
    sample();
    chk("t4_b_rvalid_wr", 64'(b_rvalid), 64'(0));
    next_cycle();
    idle_inputs();
    sample();
    chk("t4_b_rvalid", 64'(b_rvalid), 64'(1));
    chk("t4_b_rdata",  64'(b_rdata),  64'(32'hDEAD3380));
    next_cycle();

    // Lock cap: a goes once so b wins the first contest, then b holds the lock.
    a_valid = 1; a_addr = 32'h104;
    sample();
    next_cycle();
    a_valid = 1; a_addr = 32'h108;
    b_valid = 1; b_lock = 1; b_write = 1; b_wmask = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      b_addr  = 32'h300 + 32'(4 * k);
      b_wdata = 32'(k);
      sample();
      chk("t5_b_ready", 64'(b_ready), 64'(k != 17));
      chk("t5_a_ready", 64'(a_ready), 64'(k == 17));
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Reset right after a read: response dropped, a wins first contest, then a lock.
    a_valid = 1; a_addr = 32'h100;
    sample();
    chk("t6_a_ready", 64'(a_ready), 64'(1));
    next_cycle();
    rst = 1'b1;
    a_lock = 1; b_valid = 1; b_addr = 32'h80;
    sample();
    chk("t6_a_rvalid",   64'(a_rvalid),  64'(0));
    chk("t6_a_rdata",    64'(a_rdata),   64'(0));
    chk("t6_mem_valid",  64'(mem_valid), 64'(0));
    chk("t6_b_ready",    64'(b_ready),   64'(0));
    next_cycle();
    rst = 1'b0;
    sample();
    chk("t6_first_a",  64'(a_ready),  64'(1));
    chk("t6_first_b",  64'(b_ready),  64'(0));
    chk("t6_no_rvalid", 64'(a_rvalid), 64'(0));
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("t6_lock_a", 64'(a_ready), 64'(1));
      next_cycle();
    end
    a_lock = 0;
    sample();
    chk("t6_release_b", 64'(b_ready), 64'(1));
    chk("t6_release_a", 64'(a_ready), 64'(0));
    next_cycle();
    idle_inputs();
    sample();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
